btn_conditioner: RTL

Conditions the raw DE10-Lite push-button before it reaches the Nios system's `btn0_export` PIO input. Synchronises the asynchronous active-low key and debounces it with a per-edge stability counter. Produces a clean level plus single-cycle press, release and long-press events, and a wrapping press counter. Sits directly upstream of the `maoin` system in the top level, so software reads a glitch-free button.

---
 rtl/btn_cond_pkg.sv | 17 +
 rtl/btn_sync.sv | 30 +++
 rtl/btn_conditioner.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/btn_cond_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
package btn_cond_pkg;

  // Debounce / hold FSM states
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // Defaults for a 50 MHz clock: 10 ms debounce, 1 s long press, 200 ms repeat
  localparam int unsigned BTN_DEBOUNCE_CYC_DEF = 500000;
  localparam int unsigned BTN_LONG_CYC_DEF     = 50000000;
  localparam int unsigned BTN_REPEAT_CYC_DEF   = 10000000;

endpackage : btn_cond_pkg

// File: rtl/btn_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input; reset value selectable.
module btn_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  // Shift the raw input through the two-stage chain
  always_comb begin
    sync_d = {sync_q[0], d_i};
  end

  // Synchroniser flops, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[1];

endmodule : btn_sync

// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchronise, debounce, level + press/release/long events,
// wrapping press counter. Optional auto-repeat enabled by BTN_COND_AUTOREPEAT_EN.
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = BTN_DEBOUNCE_CYC_DEF,
  parameter int unsigned LONG_CYC     = BTN_LONG_CYC_DEF,
  parameter int unsigned REPEAT_CYC   = BTN_REPEAT_CYC_DEF
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       key_n_i,
  output logic       btn_level_o,
  output logic       press_pulse_o,
  output logic       release_pulse_o,
  output logic       long_pulse_o,
  output logic [7:0] press_count_o
);

  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYC);
  localparam int unsigned HOLD_W = $clog2(LONG_CYC + 1);

  // Reject parameter values that would give zero-width counters
  if (DEBOUNCE_CYC < 2 || LONG_CYC < 2 || REPEAT_CYC < 2) begin : g_bad_param
    $error("btn_conditioner: DEBOUNCE_CYC, LONG_CYC and REPEAT_CYC must be >= 2");
  end

  logic key_s;

  btn_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk_clk),
    .rst (reset_reset),
    .d_i (key_n_i),
    .q_o (key_s)
  );

  btn_state_t        state_q,     state_d;
  logic [DEB_W-1:0]  deb_cnt_q,   deb_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
  logic              long_done_q, long_done_d;
  logic              level_q,     level_d;
  logic              press_q,     press_d;
  logic              release_q,   release_d;
  logic              long_q,      long_d;
  logic [7:0]        count_q,     count_d;

`ifdef BTN_COND_AUTOREPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_CYC);
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_fire;
`endif

  // Next-state, counters and event generation
  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    long_done_d = long_done_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    count_d     = count_q;
`ifdef BTN_COND_AUTOREPEAT_EN
    rep_cnt_d   = rep_cnt_q;
    rep_fire    = 1'b0;
`endif

    // Hold timer runs through release bounces so a glitch does not delay the long press
    if (state_q == HELD || state_q == RELEASE_WAIT) begin
      if (hold_cnt_q < HOLD_W'(LONG_CYC)) begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
      if (hold_cnt_q == HOLD_W'(LONG_CYC - 1) && !long_done_q) begin
        long_d      = 1'b1;
        long_done_d = 1'b1;
`ifdef BTN_COND_AUTOREPEAT_EN
        rep_cnt_d   = '0;
`endif
      end
`ifdef BTN_COND_AUTOREPEAT_EN
      else if (long_done_q) begin
        if (rep_cnt_q == REP_W'(REPEAT_CYC - 1)) begin
          rep_cnt_d = '0;
          rep_fire  = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + REP_W'(1);
        end
      end
`endif
    end

    case (state_q)
      IDLE: begin
        if (!key_s) begin
          state_d   = PRESS_WAIT;
          deb_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (key_s) begin
          state_d = IDLE;
        end else if (deb_cnt_q == DEB_W'(DEBOUNCE_CYC - 1)) begin
          state_d     = HELD;
          level_d     = 1'b1;
          press_d     = 1'b1;
          count_d     = count_q + 8'd1;
          hold_cnt_d  = '0;
          long_done_d = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      HELD: begin
        if (key_s) begin
          state_d   = RELEASE_WAIT;
          deb_cnt_d = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!key_s) begin
          state_d = HELD;
        end else if (deb_cnt_q == DEB_W'(DEBOUNCE_CYC - 1)) begin
          state_d   = IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
`ifdef BTN_COND_AUTOREPEAT_EN
          rep_cnt_d = '0;
          rep_fire  = 1'b0;
`endif
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef BTN_COND_AUTOREPEAT_EN
    // Auto-repeat looks like another press to software
    if (rep_fire) begin
      press_d = 1'b1;
      count_d = count_q + 8'd1;
    end
`endif
  end

  // State and output registers, synchronous active-high reset
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q     <= IDLE;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      count_q     <= 8'd0;
`ifdef BTN_COND_AUTOREPEAT_EN
      rep_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      count_q     <= count_d;
`ifdef BTN_COND_AUTOREPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
`endif
    end
  end

  assign btn_level_o     = level_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = release_q;
  assign long_pulse_o    = long_q;
  assign press_count_o   = count_q;

endmodule : btn_conditioner
